mat2x2_mul_pipe: RTL

- Pipelined 2x2 unsigned matrix multiplier, C = A x B, directly downstream of the operand memories.
- Consumes the four A elements and four B elements that the memory stages present on their registered read outputs.
- Emits the four C elements with a valid/ready handshake to the result writer.
- Three register stages (operand capture, products, sums), with per-stage advance so bubbles compress and back-pressure stalls cleanly.

---
 rtl/mat_pkg.sv | 27 ++
 rtl/mat2x2_mul_pipe_dot2.sv | 48 ++++
 rtl/mat2x2_mul_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared widths, element/result types and row-major index constants for the 2x2 multiplier.
package mat_pkg;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned RW = 2 * DW + 1;

    localparam logic [1:0] IDX_00 = 2'd0;
    localparam logic [1:0] IDX_01 = 2'd1;
    localparam logic [1:0] IDX_10 = 2'd2;
    localparam logic [1:0] IDX_11 = 2'd3;

    typedef logic [DW-1:0] elem_t;
    typedef logic [PW-1:0] prod_t;
    typedef logic [RW-1:0] res_t;

    // One operand set as presented by the memory read stages, row-major.
    typedef struct packed {
        elem_t [3:0] a;
        elem_t [3:0] b;
    } operands_t;

    typedef struct packed {
        res_t [3:0] c;
    } results_t;

endpackage

// File: rtl/mat2x2_mul_pipe_dot2.sv
// Two-term dot product x0*y0 + x1*y1: registered products, then registered sum.
module dot2_pipe
    import mat_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  ld_prod,
    input  logic  ld_sum,
    input  elem_t x0,
    input  elem_t y0,
    input  elem_t x1,
    input  elem_t y1,
    output res_t  sum
);

    prod_t p0_q, p0_d;
    prod_t p1_q, p1_d;
    res_t  sum_q, sum_d;

    always_comb begin
        p0_d  = p0_q;
        p1_d  = p1_q;
        sum_d = sum_q;
        if (ld_prod) begin
            p0_d = PW'(x0) * PW'(y0);
            p1_d = PW'(x1) * PW'(y1);
        end
        // Sum uses the products registered before this edge.
        if (ld_sum) begin
            sum_d = RW'(p0_q) + RW'(p1_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_q  <= '0;
            p1_q  <= '0;
            sum_q <= '0;
        end else begin
            p0_q  <= p0_d;
            p1_q  <= p1_d;
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/mat2x2_mul_pipe.sv
// Three-stage pipelined 2x2 unsigned matrix multiply C = A x B with valid/ready on both sides.
module mat2x2_mul_pipe
    import mat_pkg::*;
#(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  elem_t           a0,
    input  elem_t           a1,
    input  elem_t           a2,
    input  elem_t           a3,
    input  elem_t           b0,
    input  elem_t           b1,
    input  elem_t           b2,
    input  elem_t           b3,
    output logic            out_valid,
    input  logic            out_ready,
    output res_t            c0,
    output res_t            c1,
    output res_t            c2,
    output res_t            c3,
    output logic [CNTW-1:0] result_count
);

    logic            s1_v_q, s1_v_d;
    logic            s2_v_q, s2_v_d;
    logic            s3_v_q, s3_v_d;
    operands_t       ops_q, ops_d;
    logic [CNTW-1:0] result_count_q, result_count_d;
    logic            adv1_c, adv2_c, adv3_c, out_fire_c;

    // Per-stage advance: a stage loads when it has room or its occupant moves on this edge.
    always_comb begin
        adv3_c     = s2_v_q && (!s3_v_q || out_ready);
        adv2_c     = s1_v_q && (!s2_v_q || adv3_c);
        in_ready   = !s1_v_q || adv2_c;
        adv1_c     = in_valid && in_ready;
        out_fire_c = s3_v_q && out_ready;

        s1_v_d = adv1_c ? 1'b1 : (adv2_c ? 1'b0 : s1_v_q);
        s2_v_d = adv2_c ? 1'b1 : (adv3_c ? 1'b0 : s2_v_q);
        s3_v_d = adv3_c ? 1'b1 : (out_fire_c ? 1'b0 : s3_v_q);

        ops_d = ops_q;
        if (adv1_c) begin
            ops_d.a[IDX_00] = a0;
            ops_d.a[IDX_01] = a1;
            ops_d.a[IDX_10] = a2;
            ops_d.a[IDX_11] = a3;
            ops_d.b[IDX_00] = b0;
            ops_d.b[IDX_01] = b1;
            ops_d.b[IDX_10] = b2;
            ops_d.b[IDX_11] = b3;
        end

        result_count_d = result_count_q + CNTW'(out_fire_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_q         <= 1'b0;
            s2_v_q         <= 1'b0;
            s3_v_q         <= 1'b0;
            ops_q          <= '0;
            result_count_q <= '0;
        end else begin
            s1_v_q         <= s1_v_d;
            s2_v_q         <= s2_v_d;
            s3_v_q         <= s3_v_d;
            ops_q          <= ops_d;
            result_count_q <= result_count_d;
        end
    end

    // c[i][j] = a[i][0]*b[0][j] + a[i][1]*b[1][j]
    dot2_pipe u_dot_00 (
        .clk(clk), .rst(rst), .ld_prod(adv2_c), .ld_sum(adv3_c),
        .x0(ops_q.a[IDX_00]), .y0(ops_q.b[IDX_00]),
        .x1(ops_q.a[IDX_01]), .y1(ops_q.b[IDX_10]),
        .sum(c0)
    );

    dot2_pipe u_dot_01 (
        .clk(clk), .rst(rst), .ld_prod(adv2_c), .ld_sum(adv3_c),
        .x0(ops_q.a[IDX_00]), .y0(ops_q.b[IDX_01]),
        .x1(ops_q.a[IDX_01]), .y1(ops_q.b[IDX_11]),
        .sum(c1)
    );

    dot2_pipe u_dot_10 (
        .clk(clk), .rst(rst), .ld_prod(adv2_c), .ld_sum(adv3_c),
        .x0(ops_q.a[IDX_10]), .y0(ops_q.b[IDX_00]),
        .x1(ops_q.a[IDX_11]), .y1(ops_q.b[IDX_10]),
        .sum(c2)
    );

    dot2_pipe u_dot_11 (
        .clk(clk), .rst(rst), .ld_prod(adv2_c), .ld_sum(adv3_c),
        .x0(ops_q.a[IDX_10]), .y0(ops_q.b[IDX_01]),
        .x1(ops_q.a[IDX_11]), .y1(ops_q.b[IDX_11]),
        .sum(c3)
    );

    assign out_valid    = s3_v_q;
    assign result_count = result_count_q;

endmodule
